// File: rtl/ccc_lock_reset_seq.sv
// ccc_lock_reset_seq
// Turns the asynchronous PLL LOCK into a clean, registered reset for logic
// in the GL0 domain. Lock is synchronized, qualified for LOCK_STABLE_CYCLES,
// reset is held a further RST_HOLD_CYCLES, then released. Losing lock while
// running re-asserts reset on the same edge the FSM sees it and is logged in
// a sticky flag plus a saturating event counter.
module ccc_lock_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int RST_HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES     = 65536,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock,
    input  logic                  clr_lost,
    output logic                  rst_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic                  lock_timeout
);

    // Stable/hold counters only ever reach N-1; the timeout counter must be
    // able to hold TIMEOUT_CYCLES itself.
    localparam int ST_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int HD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Two-flop synchronizer; only lock_s is visible to the FSM.
    logic lock_p0;
    logic lock_s;

    state_t                state;
    state_t                state_next;
    logic [ST_W-1:0]       stable_cnt;
    logic [ST_W-1:0]       stable_cnt_next;
    logic [HD_W-1:0]       hold_cnt;
    logic [HD_W-1:0]       hold_cnt_next;
    logic [TO_W-1:0]       to_cnt;
    logic [TO_W-1:0]       to_cnt_next;
    logic [TO_W-1:0]       to_cnt_inc;
    logic                  timeout_next;
    logic                  lost_next;
    logic [LOSS_CNT_W-1:0] loss_cnt_next;

    // Saturating increment of the WAIT_LOCK timeout counter.
    function automatic logic [TO_W-1:0] sat_inc_to(input logic [TO_W-1:0] v);
        return (v == TO_MAX) ? v : v + TO_W'(1);
    endfunction

    // Saturating increment of the lock-loss event counter (sticks at all-ones).
    function automatic logic [LOSS_CNT_W-1:0] sat_inc_loss(input logic [LOSS_CNT_W-1:0] v);
        return (&v) ? v : v + LOSS_CNT_W'(1);
    endfunction

    // Synchronize the asynchronous PLL lock into the GL0 domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= lock;
            lock_s  <= lock_p0;
        end
    end

    // Next-state, counter and status logic for the lock qualification FSM.
    always_comb begin
        state_next      = state;
        stable_cnt_next = stable_cnt;
        hold_cnt_next   = hold_cnt;
        to_cnt_next     = to_cnt;
        timeout_next    = lock_timeout;
        lost_next       = lock_lost;
        loss_cnt_next   = lock_loss_cnt;
        to_cnt_inc      = sat_inc_to(to_cnt);

        // A clear is overridden below when a loss lands in the same cycle.
        if (clr_lost) begin
            lost_next     = 1'b0;
            loss_cnt_next = '0;
        end

        case (state)
            WAIT_LOCK: begin
                to_cnt_next = to_cnt_inc;
                if (to_cnt_inc == TO_MAX) begin
                    timeout_next = 1'b1;
                end
                if (lock_s) begin
                    state_next      = STABLE;
                    stable_cnt_next = '0;
                end
            end

            STABLE: begin
                if (!lock_s) begin
                    // Lock never reached RUN, so this is not a loss event.
                    state_next  = WAIT_LOCK;
                    to_cnt_next = '0;
                end else if (stable_cnt == ST_LAST) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end else begin
                    stable_cnt_next = stable_cnt + ST_W'(1);
                end
            end

            HOLD: begin
                if (!lock_s) begin
                    state_next  = WAIT_LOCK;
                    to_cnt_next = '0;
                end else if (hold_cnt == HD_LAST) begin
                    state_next   = RUN;
                    timeout_next = 1'b0;
                end else begin
                    hold_cnt_next = hold_cnt + HD_W'(1);
                end
            end

            RUN: begin
                if (!lock_s) begin
                    state_next    = WAIT_LOCK;
                    to_cnt_next   = '0;
                    lost_next     = 1'b1;
                    loss_cnt_next = clr_lost ? LOSS_CNT_W'(1) : sat_inc_loss(lock_loss_cnt);
                end
            end

            default: begin
                state_next  = WAIT_LOCK;
                to_cnt_next = '0;
            end
        endcase
    end

    // State, counters and registered outputs; outputs follow the next state so
    // they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_LOCK;
            stable_cnt    <= '0;
            hold_cnt      <= '0;
            to_cnt        <= '0;
            rst_out       <= 1'b1;
            ready         <= 1'b0;
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
            lock_timeout  <= 1'b0;
        end else begin
            state         <= state_next;
            stable_cnt    <= stable_cnt_next;
            hold_cnt      <= hold_cnt_next;
            to_cnt        <= to_cnt_next;
            rst_out       <= (state_next != RUN);
            ready         <= (state_next == RUN);
            lock_lost     <= lost_next;
            lock_loss_cnt <= loss_cnt_next;
            lock_timeout  <= timeout_next;
        end
    end

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Bench for ccc_lock_reset_seq: expectations are scheduled per clock edge
// into a scoreboard when lock/clr_lost stimulus is driven, and compared on
// the falling edge following that rising edge.
module tb_ccc_lock_reset_seq;

    localparam int LOSS_CNT_W = 2;

    localparam int S_RST  = 0;
    localparam int S_RDY  = 1;
    localparam int S_LOST = 2;
    localparam int S_CNT  = 3;
    localparam int S_TO   = 4;

    logic                  clk;
    logic                  rst;
    logic                  lock;
    logic                  clr_lost;
    logic                  rst_out;
    logic                  ready;
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;
    logic                  lock_timeout;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_errors;

    ccc_lock_reset_seq #(
        .LOCK_STABLE_CYCLES(16),
        .RST_HOLD_CYCLES   (8),
        .TIMEOUT_CYCLES    (64),
        .LOSS_CNT_W        (LOSS_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lock         (lock),
        .clr_lost     (clr_lost),
        .rst_out      (rst_out),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .lock_loss_cnt(lock_loss_cnt),
        .lock_timeout (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to address scoreboard entries.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sig_val(input int sig);
        case (sig)
            S_RST:   return {31'd0, rst_out};
            S_RDY:   return {31'd0, ready};
            S_LOST:  return {31'd0, lock_lost};
            S_CNT:   return {{(32-LOSS_CNT_W){1'b0}}, lock_loss_cnt};
            default: return {31'd0, lock_timeout};
        endcase
    endfunction

    task automatic push(input int c, input int sig, input int val, input string tag);
        exp_t e;
        e.cyc = c;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_range(input int c0, input int c1, input int sig, input int val, input string tag);
        for (int c = c0; c <= c1; c++) push(c, sig, val, tag);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Raise lock now (first sampled on the next edge N); reset must stay high
    // through N+25 and release on N+26.
    task automatic qualify(input int exp_cnt, input int exp_lost, input string tag);
        int n;
        lock = 1'b1;
        n = cyc + 1;
        push_range(n, n + 25, S_RST, 1, {tag, "_rst_held"});
        push(n + 25, S_RDY, 0, {tag, "_ready_early"});
        push(n + 26, S_RST, 0, {tag, "_rst_release"});
        push(n + 26, S_RDY, 1, {tag, "_ready"});
        push(n + 26, S_CNT, exp_cnt, {tag, "_loss_cnt"});
        push(n + 26, S_LOST, exp_lost, {tag, "_lock_lost"});
        push(n + 26, S_TO, 0, {tag, "_timeout"});
        wait_cyc(n + 26);
    endtask

    // From RUN: drop lock for 3 samples (first at M); reset re-asserts at M+2.
    task automatic lose(input int exp_cnt, input bit with_clr, input string tag);
        int m;
        lock = 1'b0;
        m = cyc + 1;
        push(m, S_RST, 0, {tag, "_rst_still_run"});
        push(m + 1, S_RST, 0, {tag, "_rst_still_run2"});
        push(m + 1, S_RDY, 1, {tag, "_ready_still_run"});
        push(m + 2, S_RST, 1, {tag, "_rst_assert"});
        push(m + 2, S_RDY, 0, {tag, "_ready_drop"});
        push(m + 2, S_LOST, 1, {tag, "_lock_lost"});
        push(m + 2, S_CNT, exp_cnt, {tag, "_loss_cnt"});
        wait_cyc(m + 1);
        if (with_clr) clr_lost = 1'b1;
        wait_cyc(m + 2);
        clr_lost = 1'b0;
        qualify(exp_cnt, 1, {tag, "_relock"});
    endtask

    // Compare every scoreboard entry due on the edge just taken.
    always @(negedge clk) begin
        exp_t rest[$];
        rest = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) chk(sb[i].tag, sig_val(sb[i].sig), sb[i].val);
            else if (sb[i].cyc < cyc) chk({sb[i].tag, "_missed_edge"}, cyc, sb[i].cyc);
            else rest.push_back(sb[i]);
        end
        sb = rest;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int k;
        int n;
        int n2;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        lock     = 1'b0;
        clr_lost = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_rst_out", rst_out, 1);
        chk("reset_ready", ready, 0);
        chk("reset_lock_lost", lock_lost, 0);
        chk("reset_loss_cnt", lock_loss_cnt, 0);
        chk("reset_timeout", lock_timeout, 0);

        // First lock: sampled high at edge 10 after release, RUN at edge 36
        rst = 1'b0;
        c0  = cyc;
        wait_cyc(c0 + 9);
        qualify(0, 0, "first_lock");

        // Lock loss from RUN and relock
        lose(1, 1'b0, "loss1");

        // clr_lost on its own
        clr_lost = 1'b1;
        k = cyc;
        push(k + 1, S_LOST, 0, "clr_lock_lost");
        push(k + 1, S_CNT, 0, "clr_loss_cnt");
        push(k + 1, S_RDY, 1, "clr_ready");
        wait_cyc(k + 1);
        clr_lost = 1'b0;

        // Four losses: counter saturates at 3
        lose(1, 1'b0, "sat1");
        lose(2, 1'b0, "sat2");
        lose(3, 1'b0, "sat3");
        lose(3, 1'b0, "sat4");

        // clr_lost in the same cycle as a loss: the loss wins
        lose(1, 1'b1, "loss_and_clr");

        // Asynchronous reset while in RUN, lock held high
        #2 rst = 1'b1;
        #1;
        chk("arst_rst_out", rst_out, 1);
        chk("arst_ready", ready, 0);
        chk("arst_lock_lost", lock_lost, 0);
        chk("arst_loss_cnt", lock_loss_cnt, 0);
        chk("arst_timeout", lock_timeout, 0);
        @(negedge clk);
        rst = 1'b0;
        qualify(0, 0, "arst_release");

        // Timeout: lock held low after a fresh reset
        lock = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        k = cyc;
        push_range(k + 1, k + 64, S_RST, 1, "to_rst_held");
        push(k + 63, S_TO, 0, "to_not_yet");
        push(k + 64, S_TO, 1, "to_set");
        wait_cyc(k + 70);

        // Lock arrives, glitches low for 2 samples during STABLE, restarts
        n  = cyc + 1;
        n2 = n + 13;
        lock = 1'b1;
        push_range(n, n2 + 25, S_RST, 1, "glitch_rst_held");
        push(n + 26, S_RDY, 0, "glitch_no_early_ready");
        push(n2 + 25, S_TO, 1, "glitch_to_sticky");
        push(n2 + 26, S_RST, 0, "glitch_rst_release");
        push(n2 + 26, S_RDY, 1, "glitch_ready");
        push(n2 + 26, S_TO, 0, "glitch_to_clear");
        push(n2 + 26, S_CNT, 0, "glitch_loss_cnt");
        push(n2 + 26, S_LOST, 0, "glitch_lock_lost");
        wait_cyc(n + 10);
        lock = 1'b0;
        wait_cyc(n + 12);
        lock = 1'b1;
        wait_cyc(n2 + 26);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
